// File: rtl/posit_prod_accum_if.sv
// Product bus from the posit x FP16 multiplier and the rounded result bus.
interface posit_prod_accum_if;
   logic        in_valid;
   logic        in_sign;
   logic [4:0]  in_exp;
   logic [13:0] in_man;
   logic        in_zero;
   logic        in_nar;
   logic        out_valid;
   logic [15:0] out_fp16;
   logic        out_nar;
   logic        out_ovf;

   modport slave (
      input  in_valid, in_sign, in_exp, in_man, in_zero, in_nar,
      output out_valid, out_fp16, out_nar, out_ovf
   );

   modport master (
      output in_valid, in_sign, in_exp, in_man, in_zero, in_nar,
      input  out_valid, out_fp16, out_nar, out_ovf
   );
endinterface

// File: rtl/posit_prod_accum.sv
// Group accumulator for multiplier products: align -> accumulate -> round to FP16.
// Accumulator LSB weight is 2^-27; groups may follow back-to-back.
module posit_prod_accum #(
   parameter int CNT_W = 8,
   parameter int ACC_W = 46 + CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_set,
   input  logic [CNT_W-1:0] acc_len,
   output logic             busy,
   posit_prod_accum_if.slave bus
);
   localparam int POS_W = $clog2(ACC_W);

   logic [CNT_W-1:0] len_reg, cnt_reg;
   logic [CNT_W:0]   cnt_inc, len_eff;
   logic             is_last;
   logic [44:0]      mag;
   logic [ACC_W-1:0] aligned_next, aligned_reg;
   logic             a_valid_reg, a_last_reg, a_nar_reg;
   logic [ACC_W-1:0] acc_reg, norm_reg;
   logic             nar_acc_reg, norm_nar_reg, b_valid_reg;
   logic             out_valid_reg, out_nar_reg, out_ovf_reg;
   logic [15:0]      out_fp16_reg;

   // A stored length of 0 behaves as a group of one product.
   assign cnt_inc = {1'b0, cnt_reg} + 1'b1;
   assign len_eff = (len_reg == '0) ? (CNT_W+1)'(1) : {1'b0, len_reg};
   assign is_last = (cnt_inc == len_eff);
   assign mag     = {31'b0, bus.in_man} << bus.in_exp;

   // Signed, aligned product; zero and NaR contribute nothing to the sum.
   always_comb begin
      aligned_next = {{(ACC_W-45){1'b0}}, mag};
      if (bus.in_zero || bus.in_nar)
         aligned_next = '0;
      else if (bus.in_sign)
         aligned_next = -aligned_next;
   end

   // Stored group length and position within the current group.
   always_ff @(posedge clk) begin
      if (rst) begin
         len_reg <= CNT_W'(1);
         cnt_reg <= '0;
      end else begin
         if (cfg_set && !busy && !bus.in_valid)
            len_reg <= acc_len;
         if (bus.in_valid)
            cnt_reg <= is_last ? '0 : cnt_inc[CNT_W-1:0];
      end
   end

   // Stage A: register the aligned product with its last/NaR tags.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_valid_reg <= 1'b0;
         a_last_reg  <= 1'b0;
         a_nar_reg   <= 1'b0;
         aligned_reg <= '0;
      end else begin
         a_valid_reg <= bus.in_valid;
         if (bus.in_valid) begin
            aligned_reg <= aligned_next;
            a_last_reg  <= is_last;
            a_nar_reg   <= bus.in_nar;
         end
      end
   end

   // Stage B: accumulate; on the last product hand the sum off and clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_reg      <= '0;
         nar_acc_reg  <= 1'b0;
         norm_reg     <= '0;
         norm_nar_reg <= 1'b0;
         b_valid_reg  <= 1'b0;
      end else begin
         b_valid_reg <= a_valid_reg && a_last_reg;
         if (a_valid_reg) begin
            if (a_last_reg) begin
               norm_reg     <= acc_reg + aligned_reg;
               norm_nar_reg <= nar_acc_reg | a_nar_reg;
               acc_reg      <= '0;
               nar_acc_reg  <= 1'b0;
            end else begin
               acc_reg     <= acc_reg + aligned_reg;
               nar_acc_reg <= nar_acc_reg | a_nar_reg;
            end
         end
      end
   end

   // Stage C datapath: magnitude, leading one, round-to-nearest-even.
   logic             neg;
   logic [ACC_W-1:0] mag_c;
   logic [POS_W-1:0] lead_pos;
   logic [ACC_W-2:0] below;
   logic [9:0]       frac;
   logic             guard, sticky, rnd;
   logic [14:0]      rounded;
   logic [15:0]      fp_next;
   logic             ovf_next;

   always_comb begin
      neg      = norm_reg[ACC_W-1];
      mag_c    = neg ? -norm_reg : norm_reg;
      lead_pos = '0;
      for (int i = 0; i < ACC_W; i++)
         if (mag_c[i]) lead_pos = POS_W'(i);
      // Bits below the leading one, MSB-justified.
      below    = (ACC_W-1)'(mag_c << (ACC_W - 1 - int'(lead_pos)));
      frac     = 10'(below[ACC_W-2 -: 10]);
      guard    = below[ACC_W-12];
      sticky   = |below[ACC_W-13:0];
      rnd      = 1'b0;
      rounded  = '0;
      fp_next  = 16'h0000;
      ovf_next = 1'b0;
      if (norm_nar_reg) begin
         fp_next = 16'h7E00;
      end else if (mag_c == '0) begin
         fp_next = 16'h0000;
      end else if (lead_pos >= POS_W'(43)) begin
         fp_next  = {neg, 15'h7C00};
         ovf_next = 1'b1;
      end else if (lead_pos <= POS_W'(12)) begin
         // Subnormal: unit is 2^-24, i.e. M >> 3; a carry lands in the exponent.
         rnd     = mag_c[2] & ((|mag_c[1:0]) | mag_c[3]);
         rounded = {5'b0, mag_c[12:3]} + 15'(rnd);
         fp_next = {neg, rounded};
      end else begin
         rnd     = guard & (sticky | frac[0]);
         rounded = {5'(lead_pos - POS_W'(12)), frac} + 15'(rnd);
         if (rounded[14:10] == 5'h1F) begin
            fp_next  = {neg, 15'h7C00};
            ovf_next = 1'b1;
         end else begin
            fp_next = {neg, rounded};
         end
      end
   end

   // Stage C: capture the result and hold it until the next group.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_reg <= 1'b0;
         out_fp16_reg  <= 16'h0000;
         out_nar_reg   <= 1'b0;
         out_ovf_reg   <= 1'b0;
      end else begin
         out_valid_reg <= b_valid_reg;
         if (b_valid_reg) begin
            out_fp16_reg <= fp_next;
            out_nar_reg  <= norm_nar_reg;
            out_ovf_reg  <= ovf_next;
         end
      end
   end

   assign bus.out_valid = out_valid_reg;
   assign bus.out_fp16  = out_fp16_reg;
   assign bus.out_nar   = out_nar_reg;
   assign bus.out_ovf   = out_ovf_reg;
   assign busy = (cnt_reg != '0) | a_valid_reg | b_valid_reg | out_valid_reg;
endmodule

// File: doc/posit_prod_accum.md
# posit_prod_accum

Accumulates a programmable-length group of products from the bit-serial posit×FP16 multiplier (`fp_posit4_mul`) into a wide two's-complement fixed-point register. At the end of each group it normalises and rounds the sum to an IEEE FP16 result. It sits directly downstream of the multiplier: its `in_*` ports connect to the multiplier's `sign_out` / `exp_out` / `mantissa_out` / `zero_out` / `NaR_out`, and `in_valid` connects to `done`. Groups may follow back-to-back with no stall.

## Interface
Parameters:
- `CNT_W`, 8: width of the group-length counter; maximum group length is 2^CNT_W−1.
- `ACC_W`, 46+CNT_W (54): accumulator width, two's complement; LSB weight is 2^-27.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cfg_set`  in  1  load `acc_len` (accepted only when `busy`=0).
- `acc_len`  in  CNT_W  products per group; 0 is treated as 1.
- `in_valid`  in  1  one product is present this cycle (single-cycle pulse per product).
- `in_sign`  in  1  product sign.
- `in_exp`  in  5  product exponent, unsigned, bias 15.
- `in_man`  in  14  product magnitude, unsigned 2.12 fixed point.
- `in_zero`  in  1  product is zero; `in_sign`/`in_exp`/`in_man` are ignored.
- `in_nar`  in  1  product is NaR.
- `out_valid`  out  1  one-cycle pulse; result fields are valid.
- `out_fp16`  out  16  rounded group sum.
- `out_nar`  out  1  the group contained a NaR.
- `out_ovf`  out  1  the result overflowed to ±inf.
- `busy`  out  1  a group is partially accumulated, or a result is in flight.

## Operation
- Product value = (−1)^in_sign × in_man × 2^(in_exp−27).
- **Stage A (align):** on the edge that samples `in_valid`, register `{in_man, 31'b0} >> (31−in_exp)`, i.e. `in_man << in_exp`. This is 45-bit magnitude, LSB weight 2^-27. Negate if `in_sign`. Force the value to 0 if `in_zero` or `in_nar`. Register the valid, last and nar flags alongside it.
- **Group counter:** increments on each accepted product. The product whose count reaches `acc_len` is tagged "last", and the counter returns to 0.
- **Stage B (accumulate):** `acc += aligned`.
  - On a "last" product, `acc+aligned` is written to the norm register instead, and `acc` is cleared in the same edge, so the next group's first product may arrive in the very next cycle.
  - The sticky NaR flag is ORed per product and transferred and cleared in the same way.
- **Stage C (normalise/round), one edge:**
  - NaR: `out_fp16`=0x7E00, `out_nar`=1, `out_ovf`=0.
  - Sum = 0: 0x0000 (+0 always).
  - Otherwise take magnitude M and leading-one position p, and let E = p−12.
  - E ≥ 31: ±inf (0x7C00 / 0xFC00), `out_ovf`=1.
  - 1 ≤ E ≤ 30: fraction is M[p−1:p−10], rounded to nearest-even using guard = M[p−11] and sticky = OR(M[p−12:0]). A rounding carry increments E; if that makes E=31 the result is ±inf with `out_ovf`=1.
  - E ≤ 0: subnormal; fraction = M>>3, rounded nearest-even on M[2:0]. A rounding carry into bit 10 yields the smallest normal (0x0400).
- **Accumulator range:** no overflow is possible, since 2^CNT_W−1 products of < 2^45 fit in ACC_W bits.
- **`cfg_set` while `busy`=1:** ignored. `acc_len` is stored internally; the `acc_len` input port is sampled only on an accepted `cfg_set`.

## Timing
- **Reset values:** `out_valid`=0, `out_fp16`=0x0000, `out_nar`=0, `out_ovf`=0, `busy`=0. The stored `acc_len` resets to 1. The counter, `acc`, the NaR flag and all pipeline valids reset to 0.
- **Latency:** the last product is sampled on edge E0, so Stage A updates at E0, Stage B at E1 and Stage C at E2. `out_valid` is high for exactly the cycle following E2. Throughput is one product per cycle.
- **Result holding:** `out_fp16`, `out_nar` and `out_ovf` hold their values until the next `out_valid`.
- **`busy`:** equals (counter≠0) OR any stage valid.
- **Reset mid-group:** the partial sum and any in-flight result are discarded, and no `out_valid` is produced.
- **`in_valid` and `cfg_set` in the same cycle:** the product is accepted, and the `cfg_set` is ignored if the product makes `busy` true or the group was already active.

## Test plan
- **Single product:** `acc_len`=1; product sign0, exp 15, man 0x1000 → `out_valid` 3 cycles later with `out_fp16`=0x3C00, `out_nar`=0, `out_ovf`=0.
- **Cancellation and zero flag:** `acc_len`=3; products +1.0 (exp15, man 0x1000), −1.0, then one with `in_zero`=1 and man 0x3FFF → 0x0000.
- **Back-to-back groups:** `acc_len`=4; eight consecutive cycles of 1.5 (exp15, man 0x1800) → two `out_valid` pulses 4 cycles apart, each 0x4600. A subnormal group with `acc_len`=1, exp 0, man 0x1000 → 0x0200.
- **NaR, then overflow:**
  - `acc_len`=3 with a NaR as the 2nd product → 0x7E00, `out_nar`=1.
  - The next group (`acc_len`=3) of normal products yields `out_nar`=0.
  - A separate group with `acc_len`=2 and two products exp31, man 0x3FFF → 0x7C00, `out_ovf`=1.
- **Rounding:** products whose sum is exactly halfway between two FP16 values → result has even LSB. A sum of 2047×2^-11 + 2^-12 rounds up to 0x3C00.
- **Reset mid-group:** `acc_len`=4; pulse `rst` after 2 products → no `out_valid`, `busy`=0, and `acc_len` reverts to 1. A following single product of 1.0 → 0x3C00.
